shiftreg_digit: RTL

Parametrised operand serialiser for the Montgomery modular multiplier (MMM) datapath. It loads a WIDTH-bit operand and emits it as DIGIT-bit digits, LSB-first or MSB-first, for radix-2^DIGIT MMM iterations. It adds a valid/ready digit handshake, a digit index, last/done flags and a synchronous MMM clear. It sits between the operand register file and the MMM core, and replaces the single-bit operand shift register.

---
 rtl/mmm_pkg.sv | 21 ++
 rtl/digit_counter.sv | 40 ++++
 rtl/shiftreg_digit.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mmm_pkg.sv
// -----------------------------------------------------------------------------
// mmm_pkg
//   Types and helpers shared by the Montgomery modular multiplier datapath.
//   - shift_state_e : state of the operand digit serialiser.
//   - ndig()        : ceil(width / digit), the digit count of an operand.
//                     Also used by the MMM core to size its loop counters.
// -----------------------------------------------------------------------------
package mmm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // no operand loaded
    SHIFT = 2'd1,  // emitting digits
    DONE  = 2'd2   // every digit handed over, waiting for a load or clear
  } shift_state_e;

  // Number of DIGIT-bit digits needed to cover a WIDTH-bit operand.
  function automatic int ndig(input int width, input int digit);
    return (width + digit - 1) / digit;
  endfunction

endpackage : mmm_pkg

// File: rtl/digit_counter.sv
// -----------------------------------------------------------------------------
// digit_counter
//   Up-counter for the index of the digit currently offered by the serialiser.
//   Counts 0 .. NDIG; the value NDIG is only reached after the final transfer.
//
// Ports
//   clk   : clock, rising edge
//   rstb  : asynchronous active-low reset, clears the count
//   clr   : synchronous clear to zero, wins over inc
//   inc   : advance the count by one
//   cnt   : current count
//   term  : count equals NDIG-1 (the final digit)
// -----------------------------------------------------------------------------
module digit_counter #(
  parameter int NDIG  = 32,
  parameter int CNT_W = $clog2(NDIG + 1)
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             term
);

  // NOTE: state is written with non-blocking assignments so every flop samples
  // the pre-edge values, regardless of the order the blocks are evaluated in.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign term = (cnt == CNT_W'(NDIG - 1));

endmodule : digit_counter

// File: rtl/shiftreg_digit.sv
// -----------------------------------------------------------------------------
// shiftreg_digit
//   Operand serialiser for the radix-2^DIGIT Montgomery multiplier. A WIDTH-bit
//   operand is zero-extended to NDIG*DIGIT bits on load and offered to the MMM
//   core one DIGIT-bit digit at a time, LSB-first or MSB-first, under a
//   valid/ready handshake.
//
// Ports
//   clk           : clock, rising edge
//   rstb          : asynchronous active-low reset
//   en            : clock enable; when low every register holds
//   rst_mmm_i     : synchronous active-low clear (qualified by en), beats ld_a
//   ld_a          : load operand A (qualified by en), accepted in any state
//   msb_first_i   : digit order of the operand being loaded
//   A             : operand
//   digit_ready_i : consumer accepts the current digit
//   digit_o       : current digit (0 when not valid)
//   digit_valid_o : digit_o is valid
//   digit_idx_o   : index of the current digit, 0 = first emitted
//   last_o        : current digit is the final one
//   done_o        : all digits transferred; held until next load or clear
// -----------------------------------------------------------------------------
module shiftreg_digit
  import mmm_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 1,
  parameter int CNT_W = $clog2(ndig(WIDTH, DIGIT) + 1)
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             en,
  input  logic             rst_mmm_i,
  input  logic             ld_a,
  input  logic             msb_first_i,
  input  logic [WIDTH-1:0] A,
  input  logic             digit_ready_i,
  output logic [DIGIT-1:0] digit_o,
  output logic             digit_valid_o,
  output logic [CNT_W-1:0] digit_idx_o,
  output logic             last_o,
  output logic             done_o
);

  localparam int NDIG = ndig(WIDTH, DIGIT);
  localparam int PW   = NDIG * DIGIT;  // padded operand width

  shift_state_e   state_q, state_d;
  logic [PW-1:0]  sh_q;
  logic           msb_q;
  logic [CNT_W-1:0] cnt;
  logic           term;

  // ---------------------------------------------------------------------------
  // Control decode. Clear beats load, load beats a transfer, and nothing
  // happens while en is low (the handshake included).
  // ---------------------------------------------------------------------------
  logic clr, load, xfer;

  assign clr  = en && !rst_mmm_i;
  assign load = en &&  rst_mmm_i && ld_a;
  assign xfer = en &&  rst_mmm_i && !ld_a && (state_q == SHIFT) && digit_ready_i;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: state_d gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = IDLE;
    end else if (load) begin
      state_d = SHIFT;
    end else if (xfer && term) begin
      state_d = DONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Operand shift register and stored digit order. The outgoing digit always
  // sits at one end of the register, so the output is a fixed slice and each
  // transfer shifts it away with zero fill.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sh_q  <= '0;
      msb_q <= 1'b0;
    end else if (clr) begin
      sh_q  <= '0;
      msb_q <= 1'b0;
    end else if (load) begin
      sh_q  <= PW'(A);
      msb_q <= msb_first_i;
    end else if (xfer) begin
      if (msb_q) begin
        sh_q <= sh_q << DIGIT;
      end else begin
        sh_q <= sh_q >> DIGIT;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Digit index
  // ---------------------------------------------------------------------------
  digit_counter #(
    .NDIG  (NDIG),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rstb (rstb),
    .clr  (clr || load),
    .inc  (xfer),
    .cnt  (cnt),
    .term (term)
  );

  // ---------------------------------------------------------------------------
  // Outputs. Every digit-side output is gated by valid, so IDLE and DONE
  // present zeros; valid itself depends only on registered state.
  // ---------------------------------------------------------------------------
  logic [DIGIT-1:0] head;

  assign head = msb_q ? sh_q[PW-1 -: DIGIT] : sh_q[DIGIT-1:0];

  assign digit_valid_o = (state_q == SHIFT);
  assign done_o        = (state_q == DONE);
  assign digit_o       = digit_valid_o ? head : '0;
  assign digit_idx_o   = digit_valid_o ? cnt  : '0;
  assign last_o        = digit_valid_o && term;

endmodule : shiftreg_digit
